// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit producing one product or quotient bit per cycle.
// busy stalls the execute stage; result_valid/result feed the ALU result mux.
module muldiv_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            is_m_op,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            signed_a, signed_b, neg_a_in, neg_b_in, div_in, rem_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign is_m_op  = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
    assign signed_a = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) ||
                      (alu_op == OP_DIV)  || (alu_op == OP_REM);
    assign signed_b = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign neg_a_in = signed_a && src_a[XLEN-1];
    assign neg_b_in = signed_b && src_b[XLEN-1];
    assign mag_a    = neg_a_in ? -src_a : src_a;
    assign mag_b    = neg_b_in ? -src_b : src_b;
    assign div_in   = alu_op >= OP_DIV;
    assign rem_in   = alu_op >= OP_REM;
    assign div_zero = div_in && (src_b == '0);
    assign div_ovf  = ((alu_op == OP_DIV) || (alu_op == OP_REM)) &&
                      (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    // Divide-by-zero and signed overflow finish without iterating.
    assign special_res = div_zero ? (rem_in ? src_a : '1) : (rem_in ? '0 : src_a);

    logic              div_q;
    logic [XLEN:0]     add_sum, shifted, trial;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   quot_step, rem_step, quot_fix, rem_fix, final_res;

    assign div_q     = op_q >= OP_DIV;
    assign add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign prod_step = {add_sum, prod_q[XLEN-1:1]};
    assign shifted   = {rem_q, quot_q[XLEN-1]};
    assign trial     = shifted - {1'b0, opnd_q};
    assign rem_step  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quot_step = {quot_q[XLEN-2:0], ~trial[XLEN]};

    // The last iteration, sign correction and selection land in the register read during DONE.
    assign prod_fix  = (neg_a_q ^ neg_b_q) ? -prod_step : prod_step;
    assign quot_fix  = (neg_a_q ^ neg_b_q) ? -quot_step : quot_step;
    assign rem_fix   = neg_a_q ? -rem_step : rem_step;

    always_comb begin
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quot_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && is_m_op && !flush) begin
                    op_d    = alu_op;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    cnt_d   = CNT_W'(XLEN);
                    opnd_d  = div_in ? mag_b : mag_a;
                    prod_d  = {{XLEN{1'b0}}, mag_b};
                    quot_d  = mag_a;
                    rem_d   = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (div_q) begin
                        quot_d = quot_step;
                        rem_d  = rem_step;
                    end else begin
                        prod_d = prod_step;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared as well as the FSM so nothing stale survives reset.
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign result       = result_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: XLEN=32 vector table, multi-cycle corner sequences,
// a few random ops against a behavioural model, and XLEN=64 spot checks.
module tb_muldiv_iter_unit;
    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [4:0]  alu_op;
    logic [31:0] src_a, src_b, result;
    logic        is_m_op, busy, result_valid;

    logic        start64, flush64;
    logic [4:0]  alu_op64;
    logic [63:0] src_a64, src_b64, result64;
    logic        is_m_op64, busy64, result_valid64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .alu_op(alu_op),
        .src_a(src_a), .src_b(src_b), .is_m_op(is_m_op), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    muldiv_iter_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .flush(flush64), .alu_op(alu_op64),
        .src_a(src_a64), .src_b(src_b64), .is_m_op(is_m_op64), .busy(busy64),
        .result_valid(result_valid64), .result(result64)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue at a negedge, then count cycles (1 = first cycle after the accepting edge) until result_valid.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic bsy);
        @(negedge clk);
        start = 1'b1; alu_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        bsy = busy;
    endtask

    task automatic run64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        start64 = 1'b1; alu_op64 = op; src_a64 = a; src_b64 = b;
        @(negedge clk);
        start64 = 1'b0;
        lat = 1;
        while (!result_valid64 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        res = result64;
    endtask

    function automatic logic [31:0] ref32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            OP_MUL:    p = ua * ub;
            OP_MULH:   p = sa * sb;
            OP_MULHSU: p = sa * $signed(ub);
            OP_MULHU:  p = ua * ub;
            default:   p = '0;
        endcase
        case (op)
            OP_MUL:                       return p[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
            OP_DIV:  begin p = sa / sb; return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : p[31:0]); end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  begin p = sa % sb; return (b == 0) ? a : (ovf ? 32'd0 : p[31:0]); end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    initial begin
        logic [31:0] res, prev;
        logic [63:0] res64;
        logic        bsy;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          lat, pulses;

        add_vec("mulh_neg2x3",   OP_MULH,   32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 33);
        add_vec("mul_neg2x3",    OP_MUL,    32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFA, 33);
        add_vec("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add_vec("mulhsu_max",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        add_vec("mul_7x6",       OP_MUL,    32'd7,         32'd6,         32'h2A,        33);
        add_vec("mulh_minsq",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        add_vec("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        add_vec("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        add_vec("divu_big_2",    OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33);
        add_vec("div_7_m2",      OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        add_vec("rem_7_m2",      OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        add_vec("remu_100_7",    OP_REMU,   32'd100,       32'd7,         32'd2,         33);
        add_vec("divu_5_7",      OP_DIVU,   32'd5,         32'd7,         32'd0,         33);
        add_vec("div_min_1",     OP_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 33);
        add_vec("div_by0",       OP_DIV,    32'h2A,        32'd0,         32'hFFFF_FFFF, 1);
        add_vec("remu_by0",      OP_REMU,   32'h2A,        32'd0,         32'h2A,        1);
        add_vec("divu_by0",      OP_DIVU,   32'h2A,        32'd0,         32'hFFFF_FFFF, 1);
        add_vec("rem_by0",       OP_REM,    32'h2A,        32'd0,         32'h2A,        1);
        add_vec("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add_vec("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        add_vec("mul_after_ovf", OP_MUL,    32'h1234,      32'h10,        32'h12340,     33);

        rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; src_a = '0; src_b = '0;
        start64 = 1'b0; flush64 = 1'b0; alu_op64 = '0; src_a64 = '0; src_b64 = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy64", busy64, 0);
        check("rst_result64", result64, 0);
        alu_op = 5'b00000; #1 check("is_m_op_add", is_m_op, 0);
        alu_op = OP_MUL;   #1 check("is_m_op_mul", is_m_op, 1);
        alu_op = OP_REMU;  #1 check("is_m_op_remu", is_m_op, 1);
        alu_op = 5'b10011; #1 check("is_m_op_above", is_m_op, 0);
        @(negedge clk);
        rst = 1'b0;

        // A start carrying a non-M opcode is ignored.
        @(negedge clk);
        start = 1'b1; alu_op = 5'b00001; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("non_m_start_busy", busy, 0);
        @(negedge clk);
        check("non_m_start_valid", result_valid, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bsy);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy_done"}, bsy, 1);
        end
        prev = vecs[vecs.size()-1].exp;
        @(negedge clk);
        check("idle_after_done_busy", busy, 0);
        check("idle_after_done_valid", result_valid, 0);

        // Flush in cycle 10 of a MUL.
        start = 1'b1; alu_op = OP_MUL; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_c11", busy, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("flush_no_valid", pulses, 0);
        check("flush_result_kept", result, prev);

        // Reset in cycle 5 of a DIV.
        start = 1'b1; alu_op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_result", result, 0);

        // Start pulsed while busy is ignored; the latched DIVU operands survive input changes.
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        start = 1'b1; alu_op = OP_MUL; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        lat++;
        start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'd0;
        while (!result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("start_busy_res", result, 32'd14);
        check("start_busy_lat", lat, 33);
        @(negedge clk);
        check("start_busy_idle", busy, 0);
        @(negedge clk);
        check("start_busy_no_second", result_valid, 0);

        // Flush together with start in IDLE drops the start.
        start = 1'b1; flush = 1'b1; alu_op = OP_DIV; src_a = 32'h2A; src_b = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        @(negedge clk);
        check("flush_start_valid", result_valid, 0);
        check("flush_start_result", result, 32'd14);

        for (int k = 0; k < 24; k++) begin
            rop = 5'($urandom_range(11, 18));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(rop, ra, rb, res, lat, bsy);
            check($sformatf("rand%0d_op%0h_res", k, rop), res, ref32(rop, ra, rb));
            check($sformatf("rand%0d_lat", k), lat, ((rop >= OP_DIV) && (rb == 0)) ? 1 : 33);
        end

        run64(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res64, lat);
        check("x64_mulhu_res", res64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64_mulhu_lat", lat, 65);
        run64(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, res64, lat);
        check("x64_mulh_res", res64, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res64, lat);
        check("x64_div_res", res64, 64'hFFFF_FFFF_FFFF_FFFD);
        check("x64_div_lat", lat, 65);
        run64(OP_DIV, 64'h2A, 64'd0, res64, lat);
        check("x64_div0_res", res64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("x64_div0_lat", lat, 1);
        run64(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res64, lat);
        check("x64_rem_ovf_res", res64, 64'd0);
        check("x64_rem_ovf_lat", lat, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative RV32M/RV64M execution unit; successor to the execute-stage multiplier hook.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at one bit per cycle.
- Sits beside the ALU in the execute stage:
  - `busy` drives the pipeline stall.
  - `result_valid`/`result` feed the ALU result mux.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0 and alu_op is an M op
- flush  in  1  pipeline kill; aborts any operation in flight
- alu_op  in  5  MUL=01011, MULH=01100, MULHSU=01101, MULHU=01110, DIV=01111, DIVU=10000, REM=10001, REMU=10010
- src_a  in  XLEN  rs1 operand (multiplicand / dividend)
- src_b  in  XLEN  rs2 operand (multiplier / divisor)
- is_m_op  out  1  combinational: alu_op within 01011..10010
- busy  out  1  high while state != IDLE
- result_valid  out  1  one-cycle pulse when result is final
- result  out  XLEN  registered result; holds value until next accepted start

Behaviour:
- Reset: state=IDLE; busy=0; result_valid=0; result=0; counter, accumulators and op latch cleared. rst has priority over flush and start.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on `start && is_m_op`:
  - Latch op, signs and operand magnitudes: abs for signed operands; for MULHSU only src_a is signed.
  - Set counter=XLEN.
  - Go to BUSY, or directly to DONE for the special cases below.
  - Start with a non-M alu_op is ignored.
- BUSY, one iteration per cycle, counter decrements:
  - Multiply: radix-2 shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract; quotient bit = 1 when the trial remainder is >= 0.
  - At counter==1, go to DONE.
- DONE, single cycle:
  - Apply sign correction (two's-complement negate):
    - product, if signs differ;
    - quotient, if the dividend and divisor signs differ;
    - remainder, if the dividend is negative.
  - Select the result: low half for MUL; high half for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Register the result, pulse result_valid=1, return to IDLE.
- Latency:
  - Start sampled at edge of cycle 0.
  - BUSY occupies cycles 1..XLEN.
  - result_valid=1 in cycle XLEN+1.
  - busy is high in cycles 1..XLEN+1.
- Special cases, both go IDLE -> DONE, so result_valid is in cycle 1:
  - Divide by zero:
    - DIV/DIVU quotient = all ones;
    - REM/REMU remainder = src_a.
  - Signed overflow (src_a = most-negative, src_b = -1, DIV/REM only):
    - quotient = src_a;
    - remainder = 0.
- Start while busy=1: ignored. The latched operands are unaffected, even if they change on the inputs.
- Flush:
  - In BUSY or DONE: go to IDLE next cycle; result_valid stays 0 that cycle; result keeps its previous value.
  - Flush and start in the same IDLE cycle: start is dropped.
- Width rules: all arithmetic is internally XLEN+1 bits for the divide remainder and 2*XLEN bits for the product. No truncation before final selection.
- Back-to-back: a new start is accepted in the cycle after DONE (busy=0). There is no issue bubble beyond that.

Test Plan:
- MULH, src_a=0xFFFFFFFE (-2), src_b=3 -> result_valid in cycle 33, result=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFFA.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Division by zero: DIV 0x2A/0 -> 0xFFFFFFFF and REMU 0x2A/0 -> 0x2A, each with result_valid in cycle 1. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0.
- Mid-operation events:
  - Flush asserted in cycle 10 of a MUL -> busy=0 at cycle 11, no result_valid pulse, result unchanged.
  - rst asserted in cycle 5 of a DIV -> all outputs 0 next cycle.
  - start pulsed while busy -> ignored; first result still correct.
- XLEN=64: MULHU 0xFFFFFFFFFFFFFFFF^2 -> 0xFFFFFFFFFFFFFFFE with result_valid in cycle 65. Random signed/unsigned ops checked against a reference model.
